gshare_branch_predictor: RTL
============================

Name: gshare_branch_predictor

Overview:
- Parametrised successor to the 8-entry, 2-bit branch predict buffer in the dispatch unit.
- Table of saturating counters, CTR_W bits wide and 2^IDX_W entries deep.
- Optional gshare indexing: PC bits XOR a speculative global history register (GHR).
- Dispatch reads a prediction and a GHR snapshot, which travels with the branch. CDB resolution updates the counter and, on mispredict, repairs the GHR.

Parameters:
- IDX_W, 3, PC index bits (PC[IDX_W+1:2]); table depth 2^IDX_W.
- CTR_W, 2, counter width; legal 1..4.
- HIST_W, 3, GHR length; legal 1..IDX_W.
- GSHARE, 1, 1 = index is PC bits XOR zero-extended GHR; 0 = bimodal (PC bits only). GHR is still maintained in both modes.

Ports:
- Clk  in  1  single clock; all state on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Dis_BpbBranch  in  1  a branch dispatches this cycle; asserted only when dispatch actually fires.
- Dis_BpbBranchPCBits  in  IDX_W  PC index bits of the dispatching branch.
- Bpb_BranchPrediction  out  1  1 = predict taken; combinational.
- Bpb_GhrSnapshot  out  HIST_W  current GHR value, before this cycle's shift; stored with the branch.
- Dis_CdbUpdBranch  in  1  a resolved branch is on the CDB.
- Dis_CdbUpdBranchAddr  in  IDX_W  PC index bits of the resolved branch.
- Dis_CdbUpdGhr  in  HIST_W  snapshot returned with the resolved branch.
- Dis_CdbBranchOutcome  in  1  1 = taken.
- Dis_CdbMispredict  in  1  prediction was wrong; qualified by Dis_CdbUpdBranch.

Behaviour:
- Constants: WT = 2^(CTR_W-1) (weakly taken); WN = WT-1 (weakly not-taken); MAX = 2^CTR_W-1.
- Reset (async, while high): even entries = WN, odd entries = WT; GHR = 0.
  - Outputs follow combinationally: Bpb_GhrSnapshot = 0.
  - Bpb_BranchPrediction = PC-bit LSB parity of the looked-up entry (0 for even index, 1 for odd, with GHR = 0).
- Lookup index: lidx = PCBits XOR {0, GHR} if GSHARE=1, else PCBits.
- Bpb_BranchPrediction = Dis_BpbBranch ? counter[lidx] MSB : 0. Zero latency, no bypass of a same-cycle update.
- Update index: uidx = UpdAddr XOR {0, Dis_CdbUpdGhr} if GSHARE=1, else UpdAddr.
  - The index is recomputed from the returned snapshot, never from the live GHR.
- Counter update (when Dis_CdbUpdBranch = 1):
  - Taken: increment, saturate at MAX.
  - Not-taken: decrement, saturate at 0.
  - Update applies whether or not mispredicted.
- GHR next state, priority order:
  1. Dis_CdbUpdBranch && Dis_CdbMispredict: GHR <= {Dis_CdbUpdGhr[HIST_W-2:0], Outcome}; any same-cycle dispatch shift is discarded (that branch is younger and will be flushed).
  2. Dis_BpbBranch: GHR <= {GHR[HIST_W-2:0], Bpb_BranchPrediction}.
  3. Otherwise hold.
  - For HIST_W=1, the shifted value is the single new bit.
- Correct-prediction updates never modify the GHR.
- Same-cycle lookup and update of the same entry: the lookup sees the old value; the new value is visible from the next cycle.
- Reset mid-operation: everything re-initialises immediately. No pending state exists beyond the table and GHR.

Decomposition:
- Package bpb_pkg holds:
  - WT/WN/MAX as functions of CTR_W;
  - function sat_update(ctr, taken);
  - function bpb_index(pc, ghr, gshare).
- One sub-module, bpb_ghr: history register with speculative shift and mispredict restore, parameter HIST_W.
- The counter table stays in the top module.

Test Plan:
- Reset, Dis_BpbBranch=1, sweep PCBits 0..7 -> predictions 0,1,0,1,0,1,0,1; Bpb_GhrSnapshot=0 throughout.
- Three taken updates to Addr=0, Ghr=0 -> entry0 goes 01,10,11,11; prediction for PC 0 = 1. Then four not-taken updates -> 10,01,00,00; prediction = 0.
- Dispatch PC=2 (pred 0, GHR stays 000), then PC=1 (pred 1, GHR -> 001). A lookup of PC=1 now indexes entry 0 -> pred 0 (reset value). With GSHARE=0 it indexes entry 1 -> pred 1.
- Same cycle: Dis_BpbBranch=1, plus Dis_CdbUpdBranch=1 with Mispredict=1, UpdGhr=010, Outcome=1, Addr=0 -> next GHR=101 (dispatch shift dropped) and entry 2 increments to 10.
- Same cycle: lookup and taken update of entry 3 (value 10) -> prediction 1 from the old value; next cycle entry 3 = 11.
- After 5 cycles of mixed activity, pulse Reset asynchronously between clock edges -> GHR=000 and table re-initialised before the next edge. Predictions match the first test.

Source files
------------

// File: rtl/gshare_branch_predictor_pkg.sv
// bpb_pkg: counter constants, saturating update and table indexing shared by the predictor.
package bpb_pkg;
    typedef logic [3:0]  ctr_t;
    typedef logic [15:0] idx_t;
    function automatic ctr_t ctr_wt(int w);
        return ctr_t'(1 << (w - 1));
    endfunction
    function automatic ctr_t ctr_wn(int w);
        return ctr_wt(w) - 4'd1;
    endfunction
    function automatic ctr_t ctr_max(int w);
        return ctr_t'((1 << w) - 1);
    endfunction
    function automatic ctr_t sat_update(ctr_t ctr, logic taken, ctr_t max);
        return taken ? (ctr == max ? ctr : ctr + 4'd1) : (ctr == 4'd0 ? ctr : ctr - 4'd1);
    endfunction
    function automatic idx_t bpb_index(idx_t pc, idx_t ghr, bit gshare);
        return gshare ? pc ^ ghr : pc;
    endfunction
endpackage

// File: rtl/gshare_branch_predictor_if.sv
// gshare_branch_predictor_if: dispatch lookup and CDB resolution signals of the predictor.
interface gshare_branch_predictor_if #(parameter int IDX_W = 3, parameter int HIST_W = 3);
    logic              Dis_BpbBranch;
    logic [IDX_W-1:0]  Dis_BpbBranchPCBits;
    logic              Bpb_BranchPrediction;
    logic [HIST_W-1:0] Bpb_GhrSnapshot;
    logic              Dis_CdbUpdBranch;
    logic [IDX_W-1:0]  Dis_CdbUpdBranchAddr;
    logic [HIST_W-1:0] Dis_CdbUpdGhr;
    logic              Dis_CdbBranchOutcome;
    logic              Dis_CdbMispredict;
    modport master (
        output Dis_BpbBranch, Dis_BpbBranchPCBits, Dis_CdbUpdBranch, Dis_CdbUpdBranchAddr,
               Dis_CdbUpdGhr, Dis_CdbBranchOutcome, Dis_CdbMispredict,
        input  Bpb_BranchPrediction, Bpb_GhrSnapshot
    );
    modport slave (
        input  Dis_BpbBranch, Dis_BpbBranchPCBits, Dis_CdbUpdBranch, Dis_CdbUpdBranchAddr,
               Dis_CdbUpdGhr, Dis_CdbBranchOutcome, Dis_CdbMispredict,
        output Bpb_BranchPrediction, Bpb_GhrSnapshot
    );
endinterface

// File: rtl/gshare_branch_predictor_ghr.sv
// bpb_ghr: speculative global history; mispredict restore from the returned snapshot beats dispatch shift.
module bpb_ghr #(parameter int HIST_W = 3) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_shift,
    input  logic              i_shift_bit,
    input  logic              i_restore,
    input  logic [HIST_W-1:0] i_restore_ghr,
    input  logic              i_restore_bit,
    output logic [HIST_W-1:0] o_ghr
);
    logic [HIST_W-1:0] r_ghr, w_next;
    // Truncating {hist, bit} drops the oldest bit and also covers HIST_W=1.
    always_comb w_next = i_restore ? HIST_W'({i_restore_ghr, i_restore_bit})
                       : i_shift   ? HIST_W'({r_ghr, i_shift_bit}) : r_ghr;
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) r_ghr <= '0;
        else r_ghr <= w_next;
    assign o_ghr = r_ghr;
endmodule

// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor: saturating-counter table with optional gshare indexing and GHR repair.
module gshare_branch_predictor import bpb_pkg::*; #(
    parameter int IDX_W  = 3,
    parameter int CTR_W  = 2,
    parameter int HIST_W = 3,
    parameter bit GSHARE = 1'b1
) (
    input logic i_clk,
    input logic i_rst,
    gshare_branch_predictor_if.slave bpb
);
    localparam int   DEPTH = 1 << IDX_W;
    localparam ctr_t WT    = ctr_wt(CTR_W);
    localparam ctr_t WN    = ctr_wn(CTR_W);
    localparam ctr_t MAX   = ctr_max(CTR_W);
    logic [CTR_W-1:0]  r_tbl [DEPTH];
    logic [HIST_W-1:0] w_ghr;
    logic [IDX_W-1:0]  w_lidx, w_uidx;
    assign w_lidx = IDX_W'(bpb_index(idx_t'(bpb.Dis_BpbBranchPCBits), idx_t'(w_ghr), GSHARE));
    // Update index comes from the snapshot that travelled with the branch, not the live GHR.
    assign w_uidx = IDX_W'(bpb_index(idx_t'(bpb.Dis_CdbUpdBranchAddr), idx_t'(bpb.Dis_CdbUpdGhr), GSHARE));
    assign bpb.Bpb_BranchPrediction = bpb.Dis_BpbBranch & r_tbl[w_lidx][CTR_W-1];
    assign bpb.Bpb_GhrSnapshot      = w_ghr;
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) for (int i = 0; i < DEPTH; i++) r_tbl[i] <= i[0] ? CTR_W'(WT) : CTR_W'(WN);
        else if (bpb.Dis_CdbUpdBranch)
            r_tbl[w_uidx] <= CTR_W'(sat_update(ctr_t'(r_tbl[w_uidx]), bpb.Dis_CdbBranchOutcome, MAX));
    bpb_ghr #(.HIST_W(HIST_W)) u_ghr (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_shift       (bpb.Dis_BpbBranch),
        .i_shift_bit   (bpb.Bpb_BranchPrediction),
        .i_restore     (bpb.Dis_CdbUpdBranch & bpb.Dis_CdbMispredict),
        .i_restore_ghr (bpb.Dis_CdbUpdGhr),
        .i_restore_bit (bpb.Dis_CdbBranchOutcome),
        .o_ghr         (w_ghr)
    );
endmodule
